// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants: hex glyph table and dp bit position
package seg7_pkg;

  // Bit position of the decimal point within the 8-bit segment bus (bit0=a .. bit6=g).
  localparam int SEG_DP_BIT = 7;

  // Active-high glyphs for hex digits; element [n] is the pattern for nibble n.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return HEX7_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// rtl/seg7_scan_display_if.sv - host-side and pin-side signal bundle of the scanned display
interface seg7_scan_display_if #(
  parameter int N_DIGITS = 4,
  parameter int BRIGHT_W = 3
);
  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blink_mask;
  logic                  load;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  lzs_en;
  logic [BRIGHT_W-1:0]   brightness;
  logic [N_DIGITS-1:0]   dig;
  logic [7:0]            seg;
  logic                  frame_done;

  // Status/register logic drives content and controls, observes the pins.
  modport master (
    output data, dp_in, blink_mask, load, digit_en, lzs_en, brightness,
    input  dig, seg, frame_done
  );

  // The display driver consumes content and controls, drives the pins.
  modport slave (
    input  data, dp_in, blink_mask, load, digit_en, lzs_en, brightness,
    output dig, seg, frame_done
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-high 7-segment glyph
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex7(nibble_i);

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - multiplexed N-digit 7-segment scanner with shadowed content, LZS, blink and PWM
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV_LOG2  = 15,
  parameter int BRIGHT_W       = 3,
  parameter int BLINK_LOG2     = 5,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_display_if.slave  bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic DIG_OFF = (DIG_ACTIVE_LOW != 0);
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] DIG_IDLE = {N_DIGITS{DIG_OFF}};
  localparam logic [7:0] SEG_IDLE = {8{SEG_OFF}};

  // Scan position.
  logic [SCAN_DIV_LOG2-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [BLINK_LOG2:0]      blink_cnt_q, blink_cnt_d;

  // Pending shadow (written by load) and active shadow (only changes at frame wrap).
  logic [N_DIGITS-1:0][3:0] pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]      pend_blink_q, pend_blink_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [N_DIGITS-1:0][3:0] act_data_q, act_data_d;
  logic [N_DIGITS-1:0]      act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]      act_blink_q, act_blink_d;

  // Pin registers, already in pin polarity.
  logic [N_DIGITS-1:0] dig_q, dig_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_done_q;

  logic                slot_end;
  logic                frame_wrap;
  logic                blink_phase;
  logic [N_DIGITS-1:0] lzs_sup;
  logic                upper_zero;
  logic [BRIGHT_W-1:0] bright_bits;
  logic                pwm_on;
  logic                visible;
  logic                drive;
  logic [6:0]          glyph;
  logic [7:0]          seg_on;
  logic [N_DIGITS-1:0] onehot;

  assign slot_end    = &presc_q;
  assign frame_wrap  = slot_end && (idx_q == LAST_IDX);
  assign blink_phase = blink_cnt_q[BLINK_LOG2];
  assign bright_bits = presc_q[SCAN_DIV_LOG2-1 -: BRIGHT_W];

  // Free-running prescaler; digit index steps at slot end, blink counter steps per frame.
  always_comb begin
    presc_d     = presc_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    if (slot_end) begin
      idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    end
    if (frame_wrap) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // Shadow transfer: pending moves to active on the wrap; a same-cycle load refills pending afterwards.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    pend_valid_d = pend_valid_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blink_d  = act_blink_q;
    if (frame_wrap && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      act_blink_d  = pend_blink_q;
      pend_valid_d = 1'b0;
    end
    if (bus.load) begin
      pend_data_d  = bus.data;
      pend_dp_d    = bus.dp_in;
      pend_blink_d = bus.blink_mask;
      pend_valid_d = 1'b1;
    end
  end

  // Leading-zero suppression: digit i is blank when it and every digit above it hold zero.
  always_comb begin
    lzs_sup    = '0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (act_data_q[i] == 4'h0);
      lzs_sup[i] = upper_zero;
    end
  end

  seg7_hex_decode u_decode (
    .nibble_i (act_data_q[idx_q]),
    .seg_o    (glyph)
  );

  // Pin values for the current slot position, with guard cycle, PWM and polarity folded in.
  always_comb begin
    pwm_on  = (presc_q != '0) && ((bus.brightness == '1) || (bright_bits < bus.brightness));
    visible = bus.digit_en[idx_q]
              && !(bus.lzs_en && lzs_sup[idx_q])
              && !(act_blink_q[idx_q] && blink_phase);
    drive   = visible && pwm_on;
    onehot  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      onehot[i] = (idx_q == IDX_W'(i));
    end
    seg_on             = {1'b0, glyph};
    seg_on[SEG_DP_BIT] = act_dp_q[idx_q];
    dig_d = drive ? (onehot ^ DIG_IDLE) : DIG_IDLE;
    seg_d = drive ? (seg_on ^ SEG_IDLE) : SEG_IDLE;
  end

  // State and pin registers; reset blanks the pins and drops anything pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_valid_q <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      dig_q        <= DIG_IDLE;
      seg_q        <= SEG_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blink_q <= pend_blink_d;
      pend_valid_q <= pend_valid_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blink_q  <= act_blink_d;
      dig_q        <= dig_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_wrap;
    end
  end

  assign bus.dig        = dig_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display against a frame-level reference model
module tb_seg7_scan_display;

  localparam int ND  = 4;
  localparam int SDL = 4;
  localparam int BW  = 2;
  localparam int BL  = 1;
  localparam int SLOT  = 1 << SDL;
  localparam int FRAME = SLOT * ND;

  typedef struct {
    int         s;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  bm;
  } load_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_display_if #(.N_DIGITS(ND), .BRIGHT_W(BW)) bus ();

  seg7_scan_display #(
    .N_DIGITS(ND), .SCAN_DIV_LOG2(SDL), .BRIGHT_W(BW), .BLINK_LOG2(BL),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Active-low glyphs with dp off.
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  load_t loads[$];
  int st;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] ed;
  logic [7:0] es;
  logic       ef;

  task automatic tick();
    @(posedge clk);
    if (rst_n) st++;
    #1;
    bus.load = 1'b0;
    bus.data = 16'($urandom);
    bus.dp_in = 4'($urandom);
    bus.blink_mask = 4'($urandom);
  endtask

  task automatic arm_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm);
    load_t r;
    bus.data = d;
    bus.dp_in = dp;
    bus.blink_mask = bm;
    bus.load = 1'b1;
    r.s = st; r.data = d; r.dp = dp; r.bm = bm;
    loads.push_back(r);
  endtask

  // Expected pins after the edge that ends scan cycle s (cycles counted from reset release).
  function automatic void model(input int s, output logic [3:0] d_o, output logic [7:0] s_o, output logic f_o);
    int p, id, f;
    logic [15:0] ad, sh;
    logic [3:0] adp, abm, nib;
    bit sup, blank, on, drv;
    p = s % SLOT;
    id = (s / SLOT) % ND;
    f = s / FRAME;
    ad = '0; adp = '0; abm = '0;
    foreach (loads[k]) begin
      if ((loads[k].s + 1) / FRAME + 1 <= f) begin
        ad = loads[k].data; adp = loads[k].dp; abm = loads[k].bm;
      end
    end
    sh = ad >> (4 * id);
    nib = sh[3:0];
    sup = bus.lzs_en && (id > 0) && (sh == 16'h0);
    blank = abm[id] && (((f >> BL) & 1) == 1);
    on = (p != 0) && ((bus.brightness == 2'd3) || ((p >> (SDL - BW)) < int'(bus.brightness)));
    drv = bus.digit_en[id] && !sup && !blank && on;
    d_o = drv ? ~(4'b0001 << id) : 4'hF;
    s_o = drv ? (seg_tab[nib] & (adp[id] ? 8'h7F : 8'hFF)) : 8'hFF;
    f_o = (s % FRAME) == FRAME - 1;
  endfunction

  task automatic test_reset();
    bus.data = '0; bus.dp_in = '0; bus.blink_mask = '0; bus.load = 1'b0;
    bus.digit_en = 4'hF; bus.lzs_en = 1'b0; bus.brightness = 2'd3;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.dig !== 4'hF) begin n_bad++; $display("FAIL reset_dig got %b want 1111", bus.dig); end
    n_cmp++;
    if (bus.seg !== 8'hFF) begin n_bad++; $display("FAIL reset_seg got %h want ff", bus.seg); end
    n_cmp++;
    if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd got %b want 0", bus.frame_done); end
    rst_n = 1'b1;
    st = 0;
    loads.delete();
  endtask

  task automatic test_scan_load();
    bit boundary_done = 0;
    for (int j = 0; j < 5 * FRAME; j++) begin
      if (j == FRAME + 20) arm_load(16'h12AF, 4'h0, 4'h0);
      if (j == 2 * FRAME + 5) arm_load(16'h7777, 4'h0, 4'h0);
      if (j == 2 * FRAME + 30) arm_load(16'h3C7E, 4'h0, 4'h0);
      if (!boundary_done && j > 3 * FRAME && (st % FRAME) == FRAME - 1) begin
        arm_load(16'h5A69, 4'h0, 4'h0);
        boundary_done = 1;
      end
      tick();
      model(st - 1, ed, es, ef);
      n_cmp++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {ed, es, ef}) begin
        n_bad++;
        $display("FAIL scan_load s=%0d got dig=%b seg=%h fd=%b want dig=%b seg=%h fd=%b",
                 st - 1, bus.dig, bus.seg, bus.frame_done, ed, es, ef);
      end
    end
  endtask

  task automatic test_lzs();
    bus.lzs_en = 1'b1;
    for (int j = 0; j < 7 * FRAME; j++) begin
      if (j == 0) arm_load(16'h0005, 4'h0, 4'h0);
      if (j == 2 * FRAME) arm_load(16'h0000, 4'h0, 4'h0);
      if (j == 4 * FRAME) arm_load(16'h0105, 4'h0, 4'h0);
      if (j == 5 * FRAME + 10) arm_load(16'($urandom & 32'h00FF), 4'h0, 4'h0);
      if (j == 6 * FRAME + 10) arm_load(16'($urandom), 4'h0, 4'h0);
      tick();
      model(st - 1, ed, es, ef);
      n_cmp++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {ed, es, ef}) begin
        n_bad++;
        $display("FAIL lzs s=%0d got dig=%b seg=%h fd=%b want dig=%b seg=%h fd=%b",
                 st - 1, bus.dig, bus.seg, bus.frame_done, ed, es, ef);
      end
    end
    bus.lzs_en = 1'b0;
  endtask

  task automatic test_pwm();
    for (int j = 0; j < 8 * FRAME; j++) begin
      if ((j % FRAME) == 0) bus.brightness = 2'((j / FRAME) % 4);
      if (j == 4 * FRAME + 7) arm_load(16'($urandom), 4'($urandom), 4'h0);
      tick();
      model(st - 1, ed, es, ef);
      n_cmp++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {ed, es, ef}) begin
        n_bad++;
        $display("FAIL pwm s=%0d br=%0d got dig=%b seg=%h fd=%b want dig=%b seg=%h fd=%b",
                 st - 1, bus.brightness, bus.dig, bus.seg, bus.frame_done, ed, es, ef);
      end
    end
    bus.brightness = 2'd3;
  endtask

  task automatic test_blink_dp();
    for (int j = 0; j < 10 * FRAME; j++) begin
      if (j == 3) arm_load(16'h8E31, 4'b0010, 4'b0001);
      if (j == 8 * FRAME + 40) arm_load(16'($urandom), 4'($urandom), 4'($urandom));
      tick();
      model(st - 1, ed, es, ef);
      n_cmp++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {ed, es, ef}) begin
        n_bad++;
        $display("FAIL blink_dp s=%0d got dig=%b seg=%h fd=%b want dig=%b seg=%h fd=%b",
                 st - 1, bus.dig, bus.seg, bus.frame_done, ed, es, ef);
      end
    end
  endtask

  task automatic test_reset_mid();
    while ((st % SLOT) != 6) tick();
    arm_load(16'hBEEF, 4'hF, 4'h0);
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.dig !== 4'hF) begin n_bad++; $display("FAIL reset_mid_dig got %b want 1111", bus.dig); end
    n_cmp++;
    if (bus.seg !== 8'hFF) begin n_bad++; $display("FAIL reset_mid_seg got %h want ff", bus.seg); end
    n_cmp++;
    if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_mid_fd got %b want 0", bus.frame_done); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    st = 0;
    loads.delete();
    for (int j = 0; j < 3 * FRAME; j++) begin
      tick();
      model(st - 1, ed, es, ef);
      n_cmp++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {ed, es, ef}) begin
        n_bad++;
        $display("FAIL reset_mid_scan s=%0d got dig=%b seg=%h fd=%b want dig=%b seg=%h fd=%b",
                 st - 1, bus.dig, bus.seg, bus.frame_done, ed, es, ef);
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(15) == 0) begin
        bus.digit_en = 4'($urandom);
        bus.lzs_en = 1'($urandom);
        bus.brightness = 2'($urandom);
      end
      if ($urandom_range(39) == 0) begin
        arm_load(($urandom_range(1) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom),
                 4'($urandom), 4'($urandom));
      end
      tick();
      model(st - 1, ed, es, ef);
      n_cmp++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {ed, es, ef}) begin
        n_bad++;
        $display("FAIL random s=%0d got dig=%b seg=%h fd=%b want dig=%b seg=%h fd=%b",
                 st - 1, bus.dig, bus.seg, bus.frame_done, ed, es, ef);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_load();
    test_lzs();
    test_pwm();
    test_blink_dp();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
